// File: rtl/bd_dma_pkg.sv
// rtl/bd_dma_pkg.sv - shared types and constants for the BD fetch/issue path
// Purpose: channel enumeration, BD geometry, command/fetch field layout,
//          issuer FSM state type and BD address field helpers.
// Ports:   none (package).
package bd_dma_pkg;

   typedef enum logic [1:0] {
      CH_S2C0 = 2'd0,
      CH_C2S0 = 2'd1,
      CH_S2C1 = 2'd2,
      CH_C2S1 = 2'd3
   } bd_ch_e;

   localparam int NUM_CH        = 4;
   localparam int BD_SIZE_LOG2  = 5;
   localparam int BD_PER_BLOCK  = 16;
   localparam int ENTRY_W       = 4;
   localparam int BLOCK_ADDR_W  = 23;
   localparam int TAG_W         = 8;
   localparam int CMD_W         = 44;
   localparam int CMD_ADDR_LSB  = 0;
   localparam int CMD_ENTRY_LSB = 32;
   localparam int CMD_TAG_LSB   = 36;
   localparam int FETCH_W       = 25;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOOKUP    = 3'd1,
      ST_FETCH     = 3'd2,
      ST_WAIT_FILL = 3'd3,
      ST_ISSUE     = 3'd4
   } fsm_state_e;

   // Entry index of a BD inside its 512B block.
   function automatic logic [ENTRY_W-1:0] bd_entry(input logic [31:0] bd_addr);
      return bd_addr[8:5];
   endfunction

   // 512B-aligned block address of a BD.
   function automatic logic [BLOCK_ADDR_W-1:0] bd_block(input logic [31:0] bd_addr);
      return bd_addr[31:9];
   endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - 4-requester round-robin arbiter (combinational)
// Purpose: picks the first asserted request at or after the pointer.
// Ports:   req       in  4  request vector
//          ptr       in  2  current round-robin pointer
//          grant     out 4  one-hot grant (zero when no request)
//          grant_idx out 2  index of the granted requester
//          grant_any out 1  any request granted
//          next_ptr  out 2  pointer value after this grant (grant_idx+1 mod 4)
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] grant,
   output logic [1:0] grant_idx,
   output logic       grant_any,
   output logic [1:0] next_ptr
);

   logic [1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = '0;
      // Scan from farthest to nearest offset so the nearest one wins.
      for (int i = 3; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (req[idx]) begin
            grant_idx = idx;
            grant_any = 1'b1;
         end
      end
      if (grant_any) begin
         grant[grant_idx] = 1'b1;
      end
      next_ptr = grant_idx + 2'd1;
   end

endmodule

// File: rtl/bd_fetch_issuer.sv
// rtl/bd_fetch_issuer.sv - BD request arbiter, buffer lookup and block fetch initiator
// Purpose: arbitrates BD requests from 4 DMA channels, checks the resident BD block,
//          issues a buffer read command on a hit or fetches the 512B block first on a miss.
// Ports:   user_clk / user_reset_n          clock, async active-low reset
//          s_bd_req_valid/ready/addr/tag    per-channel request in, one-hot accept pulse
//          bd_buf_chN_{s2c,c2s}_addr/valid  resident block address and per-entry valid
//          m_axis_buffer_cmd_*              one-cycle buffer read command, tdest=channel
//          m_axis_bd_fetch_*                block fetch request to the PCIe read path
//          err_timeout / err_ch             dropped-request pulse and its channel
module bd_fetch_issuer
   import bd_dma_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int MAX_RETRY      = 3
) (
   input  logic                    user_clk,
   input  logic                    user_reset_n,
   input  logic [3:0]              s_bd_req_valid,
   output logic [3:0]              s_bd_req_ready,
   input  logic [127:0]            s_bd_req_addr,
   input  logic [31:0]             s_bd_req_tag,
   input  logic [BLOCK_ADDR_W-1:0] bd_buf_ch0_s2c_addr,
   input  logic [BLOCK_ADDR_W-1:0] bd_buf_ch0_c2s_addr,
   input  logic [BLOCK_ADDR_W-1:0] bd_buf_ch1_s2c_addr,
   input  logic [BLOCK_ADDR_W-1:0] bd_buf_ch1_c2s_addr,
   input  logic [BD_PER_BLOCK-1:0] bd_buf_ch0_s2c_valid,
   input  logic [BD_PER_BLOCK-1:0] bd_buf_ch0_c2s_valid,
   input  logic [BD_PER_BLOCK-1:0] bd_buf_ch1_s2c_valid,
   input  logic [BD_PER_BLOCK-1:0] bd_buf_ch1_c2s_valid,
   output logic [CMD_W-1:0]        m_axis_buffer_cmd_tdata,
   output logic                    m_axis_buffer_cmd_tvalid,
   output logic [1:0]              m_axis_buffer_cmd_tdest,
   output logic [FETCH_W-1:0]      m_axis_bd_fetch_tdata,
   output logic                    m_axis_bd_fetch_tvalid,
   input  logic                    m_axis_bd_fetch_tready,
   output logic                    err_timeout,
   output logic [1:0]              err_ch
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   fsm_state_e        state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [1:0]        ch_q, ch_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [TW-1:0]     timeout_q, timeout_d;
   logic [RW-1:0]     retry_q, retry_d;
   logic              err_pulse_q, err_pulse_d;
   logic [1:0]        err_ch_q, err_ch_d;

   logic [3:0]        grant;
   logic [1:0]        grant_idx;
   logic              grant_any;
   logic [1:0]        next_ptr;

   logic [31:0]             req_addr [NUM_CH];
   logic [TAG_W-1:0]        req_tag  [NUM_CH];
   logic [BLOCK_ADDR_W-1:0] st_addr  [NUM_CH];
   logic [BD_PER_BLOCK-1:0] st_valid [NUM_CH];
   logic                    hit;
   logic                    timeout_last;
   logic                    retry_last;

   rr_arbiter4 u_arb (
      .req       (s_bd_req_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any),
      .next_ptr  (next_ptr)
   );

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         req_addr[c] = s_bd_req_addr[32*c +: 32];
         req_tag[c]  = s_bd_req_tag[8*c +: 8];
      end
      st_addr[0]  = bd_buf_ch0_s2c_addr;
      st_addr[1]  = bd_buf_ch0_c2s_addr;
      st_addr[2]  = bd_buf_ch1_s2c_addr;
      st_addr[3]  = bd_buf_ch1_c2s_addr;
      st_valid[0] = bd_buf_ch0_s2c_valid;
      st_valid[1] = bd_buf_ch0_c2s_valid;
      st_valid[2] = bd_buf_ch1_s2c_valid;
      st_valid[3] = bd_buf_ch1_c2s_valid;
   end

   // Hit is only ever evaluated against the latched request, never live inputs.
   assign hit          = (st_addr[ch_q] == bd_block(addr_q)) & st_valid[ch_q][bd_entry(addr_q)];
   assign timeout_last = (timeout_q == TW'(TIMEOUT_CYCLES - 1));
   assign retry_last   = (retry_q == RW'(MAX_RETRY));

   // State and datapath registers.
   always_ff @(posedge user_clk or negedge user_reset_n) begin
      if (!user_reset_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         tag_q       <= '0;
         ch_q        <= '0;
         ptr_q       <= '0;
         timeout_q   <= '0;
         retry_q     <= '0;
         err_pulse_q <= 1'b0;
         err_ch_q    <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         tag_q       <= tag_d;
         ch_q        <= ch_d;
         ptr_q       <= ptr_d;
         timeout_q   <= timeout_d;
         retry_q     <= retry_d;
         err_pulse_q <= err_pulse_d;
         err_ch_q    <= err_ch_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      tag_d       = tag_q;
      ch_d        = ch_q;
      ptr_d       = ptr_q;
      timeout_d   = timeout_q;
      retry_d     = retry_q;
      err_pulse_d = 1'b0;
      err_ch_d    = err_ch_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_any) begin
               addr_d  = req_addr[grant_idx];
               tag_d   = req_tag[grant_idx];
               ch_d    = grant_idx;
               ptr_d   = next_ptr;
               retry_d = '0;
               state_d = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            state_d = hit ? ST_ISSUE : ST_FETCH;
         end
         ST_FETCH: begin
            if (m_axis_bd_fetch_tready) begin
               timeout_d = '0;
               state_d   = ST_WAIT_FILL;
            end
         end
         ST_WAIT_FILL: begin
            // A fill landing on the last timeout cycle still wins over a retry.
            if (hit) begin
               state_d = ST_ISSUE;
            end else if (timeout_last) begin
               if (!retry_last) begin
                  retry_d = retry_q + RW'(1);
                  state_d = ST_FETCH;
               end else begin
                  err_pulse_d = 1'b1;
                  err_ch_d    = ch_q;
                  state_d     = ST_IDLE;
               end
            end else begin
               timeout_d = timeout_q + TW'(1);
            end
         end
         ST_ISSUE: begin
            retry_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs decoded from state; buses read zero whenever their valid is low.
   always_comb begin
      s_bd_req_ready           = '0;
      m_axis_buffer_cmd_tvalid = 1'b0;
      m_axis_buffer_cmd_tdata  = '0;
      m_axis_buffer_cmd_tdest  = '0;
      m_axis_bd_fetch_tvalid   = 1'b0;
      m_axis_bd_fetch_tdata    = '0;
      case (state_q)
         ST_IDLE: begin
            // Ready is combinational from valid, so hold it low while in reset.
            s_bd_req_ready = grant & {4{user_reset_n}};
         end
         ST_FETCH: begin
            m_axis_bd_fetch_tvalid = 1'b1;
            m_axis_bd_fetch_tdata  = {ch_q, bd_block(addr_q)};
         end
         ST_ISSUE: begin
            m_axis_buffer_cmd_tvalid = 1'b1;
            m_axis_buffer_cmd_tdata  = {tag_q, bd_entry(addr_q), addr_q};
            m_axis_buffer_cmd_tdest  = ch_q;
         end
         default: begin
         end
      endcase
   end

   assign err_timeout = err_pulse_q;
   assign err_ch      = err_ch_q;

endmodule

// File: tb/tb_bd_fetch_issuer.sv
// tb/tb_bd_fetch_issuer.sv - self-checking bench for bd_fetch_issuer
module tb_bd_fetch_issuer;

   localparam int TO = 16;
   localparam int MR = 1;

   logic          user_clk = 1'b0;
   logic          user_reset_n;
   logic [3:0]    s_bd_req_valid;
   logic [3:0]    s_bd_req_ready;
   logic [127:0]  s_bd_req_addr;
   logic [31:0]   s_bd_req_tag;
   logic [22:0]   buf_addr [4];
   logic [15:0]   buf_valid [4];
   logic [43:0]   m_axis_buffer_cmd_tdata;
   logic          m_axis_buffer_cmd_tvalid;
   logic [1:0]    m_axis_buffer_cmd_tdest;
   logic [24:0]   m_axis_bd_fetch_tdata;
   logic          m_axis_bd_fetch_tvalid;
   logic          m_axis_bd_fetch_tready;
   logic          err_timeout;
   logic [1:0]    err_ch;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [45:0] exp_q [$];

   logic [45:0] obs_cmd [$];
   int          obs_cmd_cyc [$];
   logic [24:0] obs_fetch [$];
   int          obs_fetch_cyc [$];
   int          obs_grant [$];
   int          obs_grant_cyc [$];
   logic [1:0]  obs_err [$];
   int          obs_err_cyc [$];

   bd_fetch_issuer #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
      .user_clk                 (user_clk),
      .user_reset_n             (user_reset_n),
      .s_bd_req_valid           (s_bd_req_valid),
      .s_bd_req_ready           (s_bd_req_ready),
      .s_bd_req_addr            (s_bd_req_addr),
      .s_bd_req_tag             (s_bd_req_tag),
      .bd_buf_ch0_s2c_addr      (buf_addr[0]),
      .bd_buf_ch0_c2s_addr      (buf_addr[1]),
      .bd_buf_ch1_s2c_addr      (buf_addr[2]),
      .bd_buf_ch1_c2s_addr      (buf_addr[3]),
      .bd_buf_ch0_s2c_valid     (buf_valid[0]),
      .bd_buf_ch0_c2s_valid     (buf_valid[1]),
      .bd_buf_ch1_s2c_valid     (buf_valid[2]),
      .bd_buf_ch1_c2s_valid     (buf_valid[3]),
      .m_axis_buffer_cmd_tdata  (m_axis_buffer_cmd_tdata),
      .m_axis_buffer_cmd_tvalid (m_axis_buffer_cmd_tvalid),
      .m_axis_buffer_cmd_tdest  (m_axis_buffer_cmd_tdest),
      .m_axis_bd_fetch_tdata    (m_axis_bd_fetch_tdata),
      .m_axis_bd_fetch_tvalid   (m_axis_bd_fetch_tvalid),
      .m_axis_bd_fetch_tready   (m_axis_bd_fetch_tready),
      .err_timeout              (err_timeout),
      .err_ch                   (err_ch)
   );

   always #5 user_clk = ~user_clk;

   always @(posedge user_clk) cyc <= cyc + 1;

   always @(negedge user_clk) begin
      if (m_axis_buffer_cmd_tvalid) begin
         obs_cmd.push_back({m_axis_buffer_cmd_tdest, m_axis_buffer_cmd_tdata});
         obs_cmd_cyc.push_back(cyc);
      end
      if (m_axis_bd_fetch_tvalid && m_axis_bd_fetch_tready) begin
         obs_fetch.push_back(m_axis_bd_fetch_tdata);
         obs_fetch_cyc.push_back(cyc);
      end
      for (int c = 0; c < 4; c++) begin
         if (s_bd_req_ready[c]) begin
            obs_grant.push_back(c);
            obs_grant_cyc.push_back(cyc);
         end
      end
      if (err_timeout) begin
         obs_err.push_back(err_ch);
         obs_err_cyc.push_back(cyc);
      end
   end

   // Reference command: {tdest, tag, entry=addr[8:5], addr}.
   function automatic logic [45:0] model_cmd(input int c, input logic [31:0] a, input logic [7:0] t);
      logic [1:0] cc;
      cc = c[1:0];
      return {cc, t, a[8:5], a};
   endfunction

   function automatic logic [24:0] model_fetch(input int c, input logic [31:0] a);
      logic [1:0] cc;
      cc = c[1:0];
      return {cc, a[31:9]};
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge user_clk);
      #1;
   endtask

   task automatic send_req(input int c, input logic [31:0] a, input logic [7:0] t,
                           output bit ok, output int acc_cyc);
      ok = 1'b0;
      acc_cyc = -1;
      s_bd_req_addr[32*c +: 32] = a;
      s_bd_req_tag[8*c +: 8]    = t;
      s_bd_req_valid[c]         = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge user_clk);
         if (s_bd_req_ready[c]) begin
            ok = 1'b1;
            acc_cyc = cyc;
         end
      end
      @(posedge user_clk);
      #1;
      s_bd_req_valid[c] = 1'b0;
   endtask

   task automatic test_reset();
      user_reset_n = 1'b0;
      wait_cycles(3);
      total++; if (m_axis_buffer_cmd_tvalid !== 1'b0) begin bad++; $display("FAIL rst_cmd_tvalid got=%b want=0", m_axis_buffer_cmd_tvalid); end
      total++; if (m_axis_bd_fetch_tvalid !== 1'b0) begin bad++; $display("FAIL rst_fetch_tvalid got=%b want=0", m_axis_bd_fetch_tvalid); end
      total++; if (s_bd_req_ready !== 4'h0) begin bad++; $display("FAIL rst_ready got=%h want=0", s_bd_req_ready); end
      user_reset_n = 1'b1;
      wait_cycles(2);
      total++; if ({err_timeout, err_ch} !== 3'b000) begin bad++; $display("FAIL rst_err got=%b want=000", {err_timeout, err_ch}); end
      total++; if ({m_axis_buffer_cmd_tdata, m_axis_buffer_cmd_tdest} !== 46'h0) begin bad++; $display("FAIL rst_cmd_bus got=%h want=0", {m_axis_buffer_cmd_tdata, m_axis_buffer_cmd_tdest}); end
      total++; if (m_axis_bd_fetch_tdata !== 25'h0) begin bad++; $display("FAIL rst_fetch_bus got=%h want=0", m_axis_bd_fetch_tdata); end
   endtask

   task automatic test_rr();
      int gb, cb, fb, n;
      int order [5];
      logic [31:0] a [4];
      logic [45:0] e;
      order = '{0, 1, 2, 3, 0};
      gb = obs_grant.size(); cb = obs_cmd.size(); fb = obs_fetch.size();
      for (int c = 0; c < 4; c++) begin
         buf_addr[c]  = 23'h100 + 23'(c);
         buf_valid[c] = 16'hFFFF;
         a[c] = {23'h100 + 23'(c), 4'(c + 4), 5'h0};
         s_bd_req_addr[32*c +: 32] = a[c];
         s_bd_req_tag[8*c +: 8]    = 8'h10 + 8'(c);
      end
      for (int i = 0; i < 5; i++) exp_q.push_back(model_cmd(order[i], a[order[i]], 8'h10 + 8'(order[i])));
      s_bd_req_valid = 4'hF;
      n = 0;
      while (obs_grant.size() - gb < 5 && n < 40) begin
         wait_cycles(1);
         n++;
      end
      s_bd_req_valid = 4'h0;
      wait_cycles(4);
      total++; if (obs_grant.size() - gb !== 5) begin bad++; $display("FAIL rr_grant_count got=%0d want=5", obs_grant.size() - gb); end
      for (int i = 0; i < 5 && gb + i < obs_grant.size(); i++) begin
         total++; if (obs_grant[gb+i] !== order[i]) begin bad++; $display("FAIL rr_grant_%0d got=%0d want=%0d", i, obs_grant[gb+i], order[i]); end
         if (i > 0) begin
            total++; if (obs_grant_cyc[gb+i] - obs_grant_cyc[gb+i-1] !== 3) begin bad++; $display("FAIL rr_spacing_%0d got=%0d want=3", i, obs_grant_cyc[gb+i] - obs_grant_cyc[gb+i-1]); end
         end
      end
      total++; if (obs_cmd.size() - cb !== 5) begin bad++; $display("FAIL rr_cmd_count got=%0d want=5", obs_cmd.size() - cb); end
      for (int i = 0; i < 5; i++) begin
         e = exp_q.pop_front();
         if (cb + i < obs_cmd.size()) begin
            total++; if (obs_cmd[cb+i] !== e) begin bad++; $display("FAIL rr_cmd_%0d got=%h want=%h", i, obs_cmd[cb+i], e); end
         end
      end
      total++; if (obs_fetch.size() !== fb) begin bad++; $display("FAIL rr_no_fetch got=%0d want=%0d", obs_fetch.size(), fb); end
   endtask

   task automatic test_hit();
      int cb, fb, acc;
      bit ok;
      logic [45:0] e;
      cb = obs_cmd.size(); fb = obs_fetch.size();
      buf_addr[1]  = 23'h000123;
      buf_valid[1] = 16'h0008;
      exp_q.push_back(model_cmd(1, 32'h0002_4660, 8'h5A));
      send_req(1, 32'h0002_4660, 8'h5A, ok, acc);
      // Status change after accept must not matter.
      s_bd_req_addr[63:32] = 32'hFFFF_FFFF;
      wait_cycles(4);
      e = exp_q.pop_front();
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL hit_accept got=%b want=1", ok); end
      total++; if (obs_cmd.size() - cb !== 1) begin bad++; $display("FAIL hit_cmd_count got=%0d want=1", obs_cmd.size() - cb); end
      if (obs_cmd.size() > cb) begin
         total++; if (obs_cmd[cb] !== e) begin bad++; $display("FAIL hit_cmd got=%h want=%h", obs_cmd[cb], e); end
         total++; if (obs_cmd_cyc[cb] !== acc + 2) begin bad++; $display("FAIL hit_latency got=%0d want=%0d", obs_cmd_cyc[cb], acc + 2); end
      end
      total++; if (obs_fetch.size() !== fb) begin bad++; $display("FAIL hit_no_fetch got=%0d want=%0d", obs_fetch.size(), fb); end
   endtask

   task automatic test_miss_fill();
      int cb, fb, acc, n;
      bit ok;
      logic [45:0] e;
      cb = obs_cmd.size(); fb = obs_fetch.size();
      buf_addr[2]  = 23'h0;
      buf_valid[2] = 16'h0;
      m_axis_bd_fetch_tready = 1'b1;
      exp_q.push_back(model_cmd(2, 32'h0000_0A20, 8'h33));
      send_req(2, 32'h0000_0A20, 8'h33, ok, acc);
      n = 0;
      while (obs_fetch.size() == fb && n < 10) begin wait_cycles(1); n++; end
      total++; if (obs_fetch.size() - fb !== 1) begin bad++; $display("FAIL miss_fetch_count got=%0d want=1", obs_fetch.size() - fb); end
      if (obs_fetch.size() > fb) begin
         total++; if (obs_fetch[fb] !== {2'd2, 23'h5}) begin bad++; $display("FAIL miss_fetch_data got=%h want=%h", obs_fetch[fb], {2'd2, 23'h5}); end
      end
      wait_cycles(4);
      total++; if (obs_cmd.size() !== cb) begin bad++; $display("FAIL miss_early_cmd got=%0d want=%0d", obs_cmd.size(), cb); end
      buf_addr[2]  = 23'h5;
      buf_valid[2] = 16'h0002;
      wait_cycles(25);
      e = exp_q.pop_front();
      total++; if (obs_cmd.size() - cb !== 1) begin bad++; $display("FAIL miss_cmd_count got=%0d want=1", obs_cmd.size() - cb); end
      if (obs_cmd.size() > cb) begin
         total++; if (obs_cmd[cb] !== e) begin bad++; $display("FAIL miss_cmd got=%h want=%h", obs_cmd[cb], e); end
      end
      total++; if (obs_fetch.size() - fb !== 1) begin bad++; $display("FAIL miss_single_fetch got=%0d want=1", obs_fetch.size() - fb); end
   endtask

   task automatic test_backpressure();
      int cb, fb, acc, n;
      bit ok;
      logic [31:0] a;
      logic [24:0] ef;
      logic [45:0] e;
      a  = {23'h42, 4'h9, 5'h0};
      ef = model_fetch(0, a);
      cb = obs_cmd.size(); fb = obs_fetch.size();
      buf_addr[0]  = 23'h7;
      buf_valid[0] = 16'h0;
      m_axis_bd_fetch_tready = 1'b0;
      exp_q.push_back(model_cmd(0, a, 8'hC3));
      send_req(0, a, 8'hC3, ok, acc);
      n = 0;
      while (!m_axis_bd_fetch_tvalid && n < 10) begin @(negedge user_clk); n++; end
      for (int i = 0; i < 10; i++) begin
         @(negedge user_clk);
         total++; if ({m_axis_bd_fetch_tvalid, m_axis_bd_fetch_tdata} !== {1'b1, ef}) begin bad++; $display("FAIL bp_hold_%0d got=%h want=%h", i, {m_axis_bd_fetch_tvalid, m_axis_bd_fetch_tdata}, {1'b1, ef}); end
      end
      @(posedge user_clk); #1;
      m_axis_bd_fetch_tready = 1'b1;
      wait_cycles(3);
      buf_addr[0]  = 23'h42;
      buf_valid[0] = 16'h0200;
      wait_cycles(5);
      e = exp_q.pop_front();
      total++; if (obs_fetch.size() - fb !== 1) begin bad++; $display("FAIL bp_handshakes got=%0d want=1", obs_fetch.size() - fb); end
      total++; if (obs_cmd.size() - cb !== 1) begin bad++; $display("FAIL bp_cmd_count got=%0d want=1", obs_cmd.size() - cb); end
      if (obs_cmd.size() > cb) begin
         total++; if (obs_cmd[cb] !== e) begin bad++; $display("FAIL bp_cmd got=%h want=%h", obs_cmd[cb], e); end
      end
   endtask

   task automatic test_timeout();
      int cb, fb, eb, acc, n;
      bit ok;
      logic [31:0] a;
      logic [45:0] e;
      a = 32'h0004_0000;
      cb = obs_cmd.size(); fb = obs_fetch.size(); eb = obs_err.size();
      buf_addr[3]  = 23'h0;
      buf_valid[3] = 16'h0;
      m_axis_bd_fetch_tready = 1'b1;
      send_req(3, a, 8'h99, ok, acc);
      n = 0;
      while (obs_err.size() == eb && n < 100) begin wait_cycles(1); n++; end
      total++; if (obs_err.size() - eb !== 1) begin bad++; $display("FAIL to_err_count got=%0d want=1", obs_err.size() - eb); end
      total++; if (obs_fetch.size() - fb !== MR + 1) begin bad++; $display("FAIL to_fetch_count got=%0d want=%0d", obs_fetch.size() - fb, MR + 1); end
      if (obs_fetch.size() - fb >= 2) begin
         total++; if (obs_fetch[fb+1] !== model_fetch(3, a)) begin bad++; $display("FAIL to_refetch_data got=%h want=%h", obs_fetch[fb+1], model_fetch(3, a)); end
         // TO wait cycles then the re-issue cycle.
         total++; if (obs_fetch_cyc[fb+1] - obs_fetch_cyc[fb] !== TO + 1) begin bad++; $display("FAIL to_gap got=%0d want=%0d", obs_fetch_cyc[fb+1] - obs_fetch_cyc[fb], TO + 1); end
         if (obs_err.size() > eb) begin
            total++; if (obs_err_cyc[eb] !== obs_fetch_cyc[fb+1] + TO + 1) begin bad++; $display("FAIL to_err_time got=%0d want=%0d", obs_err_cyc[eb], obs_fetch_cyc[fb+1] + TO + 1); end
         end
      end
      if (obs_err.size() > eb) begin
         total++; if (obs_err[eb] !== 2'd3) begin bad++; $display("FAIL to_err_ch got=%0d want=3", obs_err[eb]); end
      end
      wait_cycles(3);
      total++; if ({err_timeout, err_ch} !== 3'b011) begin bad++; $display("FAIL to_err_hold got=%b want=011", {err_timeout, err_ch}); end
      total++; if (obs_cmd.size() !== cb) begin bad++; $display("FAIL to_no_cmd got=%0d want=%0d", obs_cmd.size(), cb); end
      buf_addr[0]  = 23'h55;
      buf_valid[0] = 16'h0001;
      a = {23'h55, 4'h0, 5'h0};
      exp_q.push_back(model_cmd(0, a, 8'hE1));
      send_req(0, a, 8'hE1, ok, acc);
      wait_cycles(4);
      e = exp_q.pop_front();
      total++; if (obs_cmd.size() - cb !== 1) begin bad++; $display("FAIL to_next_count got=%0d want=1", obs_cmd.size() - cb); end
      if (obs_cmd.size() > cb) begin
         total++; if (obs_cmd[cb] !== e) begin bad++; $display("FAIL to_next_cmd got=%h want=%h", obs_cmd[cb], e); end
      end
   endtask

   task automatic test_reset_mid();
      int cb, fb, acc, n;
      bit ok;
      logic [31:0] a;
      logic [45:0] e;
      a = {23'h300, 4'h2, 5'h0};
      fb = obs_fetch.size();
      buf_addr[1]  = 23'h123;
      buf_valid[1] = 16'hFFFF;
      m_axis_bd_fetch_tready = 1'b1;
      send_req(1, a, 8'h44, ok, acc);
      n = 0;
      while (obs_fetch.size() == fb && n < 10) begin wait_cycles(1); n++; end
      wait_cycles(3);
      #1;
      user_reset_n = 1'b0;
      #1;
      total++; if ({m_axis_bd_fetch_tvalid, m_axis_buffer_cmd_tvalid, err_timeout, s_bd_req_ready} !== 7'h0) begin bad++; $display("FAIL mid_rst_valids got=%h want=0", {m_axis_bd_fetch_tvalid, m_axis_buffer_cmd_tvalid, err_timeout, s_bd_req_ready}); end
      total++; if ({m_axis_bd_fetch_tdata, m_axis_buffer_cmd_tdata, err_ch} !== 71'h0) begin bad++; $display("FAIL mid_rst_buses got=%h want=0", {m_axis_bd_fetch_tdata, m_axis_buffer_cmd_tdata, err_ch}); end
      buf_addr[1]  = 23'h300;
      wait_cycles(2);
      user_reset_n = 1'b1;
      cb = obs_cmd.size(); fb = obs_fetch.size();
      wait_cycles(20);
      total++; if (obs_cmd.size() - cb !== 0) begin bad++; $display("FAIL mid_abandoned_cmd got=%0d want=0", obs_cmd.size() - cb); end
      total++; if (obs_fetch.size() - fb !== 0) begin bad++; $display("FAIL mid_abandoned_fetch got=%0d want=0", obs_fetch.size() - fb); end
      exp_q.push_back(model_cmd(2, 32'h0000_0A20, 8'h77));
      send_req(2, 32'h0000_0A20, 8'h77, ok, acc);
      wait_cycles(4);
      e = exp_q.pop_front();
      total++; if (obs_cmd.size() - cb !== 1) begin bad++; $display("FAIL mid_after_count got=%0d want=1", obs_cmd.size() - cb); end
      if (obs_cmd.size() > cb) begin
         total++; if (obs_cmd[cb] !== e) begin bad++; $display("FAIL mid_after_cmd got=%h want=%h", obs_cmd[cb], e); end
         total++; if (obs_cmd_cyc[cb] !== acc + 2) begin bad++; $display("FAIL mid_after_latency got=%0d want=%0d", obs_cmd_cyc[cb], acc + 2); end
      end
   endtask

   initial begin
      user_reset_n           = 1'b0;
      s_bd_req_valid         = 4'h0;
      s_bd_req_addr          = '0;
      s_bd_req_tag           = '0;
      m_axis_bd_fetch_tready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         buf_addr[c]  = '0;
         buf_valid[c] = '0;
      end
      test_reset();
      test_rr();
      test_hit();
      test_miss_fill();
      test_backpressure();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
